mic4_pulse_seq: RTL and testbench

MIC4_PULSE_SEQ -- requirements
Module: mic4_pulse_seq

---
 rtl/mic4_pulse_seq.sv | 175 +++++++++++++++++
 tb/tb_mic4_pulse_seq.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic4_pulse_seq.sv
// -----------------------------------------------------------------------------
// mic4_pulse_seq
//   NCH independent pulse-train generators. A trigger in IDLE captures that
//   channel's configuration, waits `dly` cycles, then emits rep+1 pulses of
//   `len` active cycles separated by `gap` inactive cycles. A one-cycle done
//   strobe marks the first inactive cycle after the final pulse.
//
// Ports
//   clk_in    : sole clock, rising edge
//   rst       : synchronous active-high reset (priority over abort and trig)
//   trig      : [NCH] per-channel start request, honoured only in IDLE
//   abort     : global stop, all channels to IDLE without done
//   cfg_len   : [NCH*LEN_WIDTH] active cycles per pulse (0 acts as 1)
//   cfg_dly   : [NCH*LEN_WIDTH] cycles from trigger to first pulse
//   cfg_gap   : [NCH*LEN_WIDTH] inactive cycles between pulses (0 acts as 1)
//   cfg_rep   : [NCH*REP_WIDTH] extra pulses after the first
//   cfg_pol   : [NCH] 1 = active-low output
//   pulse_out : [NCH] pulse outputs
//   busy      : [NCH] sequence in progress (delay through last active cycle)
//   done      : [NCH] one-cycle completion strobe
// -----------------------------------------------------------------------------
module mic4_pulse_seq #(
  parameter int NCH       = 4,
  parameter int LEN_WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NCH-1:0]           trig,
  input  logic                     abort,
  input  logic [NCH*LEN_WIDTH-1:0] cfg_len,
  input  logic [NCH*LEN_WIDTH-1:0] cfg_dly,
  input  logic [NCH*LEN_WIDTH-1:0] cfg_gap,
  input  logic [NCH*REP_WIDTH-1:0] cfg_rep,
  input  logic [NCH-1:0]           cfg_pol,
  output logic [NCH-1:0]           pulse_out,
  output logic [NCH-1:0]           busy,
  output logic [NCH-1:0]           done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [REP_WIDTH-1:0] REP_ONE  = REP_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0] REP_ZERO = '0;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] gap_q, gap_d;
    logic [REP_WIDTH-1:0] rep_q, rep_d;
    logic                 pol_q, pol_d;
    logic                 done_q, done_d;

    logic [LEN_WIDTH-1:0] live_len, live_dly, live_gap;
    logic [REP_WIDTH-1:0] live_rep;

    // Zero length/gap are promoted to one so the down-counters (which leave a
    // phase when they reach 1) always spend at least one cycle per phase.
    assign live_len = (cfg_len[i*LEN_WIDTH +: LEN_WIDTH] == LEN_ZERO) ?
                      LEN_ONE : cfg_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign live_gap = (cfg_gap[i*LEN_WIDTH +: LEN_WIDTH] == LEN_ZERO) ?
                      LEN_ONE : cfg_gap[i*LEN_WIDTH +: LEN_WIDTH];
    assign live_dly = cfg_dly[i*LEN_WIDTH +: LEN_WIDTH];
    assign live_rep = cfg_rep[i*REP_WIDTH +: REP_WIDTH];

    // Each phase loads its full cycle count and exits when the counter is 1,
    // so a count of N yields exactly N cycles and the counter never wraps.
    always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      gap_d   = gap_q;
      rep_d   = rep_q;
      pol_d   = pol_q;
      done_d  = 1'b0;

      if (abort) begin
        state_d = S_IDLE;
        cnt_d   = LEN_ZERO;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (trig[i]) begin
              len_d = live_len;
              gap_d = live_gap;
              rep_d = live_rep;
              pol_d = cfg_pol[i];
              if (live_dly != LEN_ZERO) begin
                state_d = S_DELAY;
                cnt_d   = live_dly;
              end else begin
                state_d = S_ACTIVE;
                cnt_d   = live_len;
              end
            end
          end
          S_DELAY: begin
            if (cnt_q == LEN_ONE) begin
              state_d = S_ACTIVE;
              cnt_d   = len_q;
            end else begin
              cnt_d = cnt_q - LEN_ONE;
            end
          end
          S_ACTIVE: begin
            if (cnt_q == LEN_ONE) begin
              if (rep_q != REP_ZERO) begin
                state_d = S_GAP;
                cnt_d   = gap_q;
                rep_d   = rep_q - REP_ONE;
              end else begin
                state_d = S_IDLE;
                cnt_d   = LEN_ZERO;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - LEN_ONE;
            end
          end
          S_GAP: begin
            if (cnt_q == LEN_ONE) begin
              state_d = S_ACTIVE;
              cnt_d   = len_q;
            end else begin
              cnt_d = cnt_q - LEN_ONE;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = LEN_ZERO;
          end
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= LEN_ZERO;
        len_q   <= LEN_ZERO;
        gap_q   <= LEN_ZERO;
        rep_q   <= REP_ZERO;
        pol_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        len_q   <= len_d;
        gap_q   <= gap_d;
        rep_q   <= rep_d;
        pol_q   <= pol_d;
        done_q  <= done_d;
      end
    end

    // Active level is the inverse of the inactive level; the inactive level
    // follows the live polarity in IDLE and the captured one while busy.
    assign busy[i]      = (state_q != S_IDLE);
    assign done[i]      = done_q;
    assign pulse_out[i] = (state_q == S_ACTIVE) ^ (busy[i] ? pol_q : cfg_pol[i]);
  end

endmodule

// File: tb/tb_mic4_pulse_seq.sv
// -----------------------------------------------------------------------------
// tb_mic4_pulse_seq
//   Self-checking bench for mic4_pulse_seq. A reference model expands every
//   accepted trigger into a queue of per-cycle expected values (delay cycles,
//   pulses, gaps, done cycle) and pops one entry per clock edge.
// -----------------------------------------------------------------------------
module tb_mic4_pulse_seq;

  localparam int NCH = 4;
  localparam int LW  = 8;
  localparam int RW  = 4;

  logic                clk_in = 1'b0;
  logic                rst;
  logic [NCH-1:0]      trig;
  logic                abort;
  logic [NCH*LW-1:0]   cfg_len, cfg_dly, cfg_gap;
  logic [NCH*RW-1:0]   cfg_rep;
  logic [NCH-1:0]      cfg_pol;
  logic [NCH-1:0]      pulse_out, busy, done;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  mic4_pulse_seq #(.NCH(NCH), .LEN_WIDTH(LW), .REP_WIDTH(RW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .trig      (trig),
    .abort     (abort),
    .cfg_len   (cfg_len),
    .cfg_dly   (cfg_dly),
    .cfg_gap   (cfg_gap),
    .cfg_rep   (cfg_rep),
    .cfg_pol   (cfg_pol),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic act;
    logic bsy;
    logic dn;
    logic pol;
  } ent_t;

  ent_t sched [NCH][$];
  ent_t cur   [NCH];

  initial for (int i = 0; i < NCH; i++) cur[i] = '0;

  task automatic build(input int ch);
    int   l, d, g, r;
    logic p;
    l = int'(cfg_len[ch*LW +: LW]); if (l == 0) l = 1;
    g = int'(cfg_gap[ch*LW +: LW]); if (g == 0) g = 1;
    d = int'(cfg_dly[ch*LW +: LW]);
    r = int'(cfg_rep[ch*RW +: RW]);
    p = cfg_pol[ch];
    repeat (d) sched[ch].push_back('{act: 1'b0, bsy: 1'b1, dn: 1'b0, pol: p});
    for (int k = 0; k <= r; k++) begin
      repeat (l) sched[ch].push_back('{act: 1'b1, bsy: 1'b1, dn: 1'b0, pol: p});
      if (k < r)
        repeat (g) sched[ch].push_back('{act: 1'b0, bsy: 1'b1, dn: 1'b0, pol: p});
    end
    sched[ch].push_back('{act: 1'b0, bsy: 1'b0, dn: 1'b1, pol: p});
  endtask

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      if (rst || abort) begin
        sched[i].delete();
        cur[i] = '0;
      end else begin
        if (!cur[i].bsy && trig[i]) build(i);
        if (sched[i].size() > 0) cur[i] = sched[i].pop_front();
        else                     cur[i] = '0;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_pulse();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++)
      v[i] = cur[i].act ^ (cur[i].bsy ? cur[i].pol : cfg_pol[i]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_busy();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = cur[i].bsy;
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_done();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = cur[i].dn;
    return v;
  endfunction

  // Advance one clock edge with the currently driven inputs, then sample.
  task automatic tick();
    @(posedge clk_in);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic set_cfg(input int ch, input int len, input int dly,
                         input int gap, input int rep, input logic pol);
    cfg_len[ch*LW +: LW] = LW'(len);
    cfg_dly[ch*LW +: LW] = LW'(dly);
    cfg_gap[ch*LW +: LW] = LW'(gap);
    cfg_rep[ch*RW +: RW] = RW'(rep);
    cfg_pol[ch]          = pol;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; trig = '1; abort = 1'b0;
    cfg_pol = 4'b1010;
    repeat (3) begin
      tick();
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL reset cyc=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 cyc, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (pulse_out !== 4'b1010 || busy !== 4'b0000 || done !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_levels pulse=%b busy=%b done=%b required 1010/0000/0000",
               pulse_out, busy, done);
    end
    rst = 1'b0; trig = '0; cfg_pol = '0;
    tick();
  endtask

  task automatic test_single();
    int hi = 0, dn_at = -1;
    set_cfg(0, 3, 0, 1, 0, 1'b0);
    trig = 4'b0001;
    for (int t = 1; t <= 7; t++) begin
      tick();
      trig = '0;
      if (pulse_out[0]) hi++;
      if (done[0]) dn_at = t;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL single t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (hi != 3 || dn_at != 4) begin
      miscompares++;
      $display("FAIL single_shape high=%0d done_at=%0d required 3/4", hi, dn_at);
    end
  endtask

  task automatic test_repeat();
    int lo = 0, dn = 0, first_lo = -1;
    set_cfg(1, 2, 5, 4, 2, 1'b1);
    trig = 4'b0010;
    for (int t = 1; t <= 25; t++) begin
      tick();
      trig = '0;
      if (!pulse_out[1]) begin lo++; if (first_lo < 0) first_lo = t; end
      if (done[1]) dn++;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL repeat t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (lo != 6 || dn != 1 || first_lo != 6) begin
      miscompares++;
      $display("FAIL repeat_shape low=%0d done=%0d first=%0d required 6/1/6", lo, dn, first_lo);
    end
    cfg_pol[1] = 1'b0;
  endtask

  task automatic test_cfg_change();
    int hi = 0;
    set_cfg(2, 4, 1, 2, 1, 1'b0);
    trig = 4'b0100;
    for (int t = 1; t <= 18; t++) begin
      tick();
      trig = '0;
      if (t == 3) begin
        trig = 4'b0100;
        cfg_len[2*LW +: LW] = 8'd7;
        cfg_gap[2*LW +: LW] = 8'd9;
      end
      if (t == 6) trig = '0;
      if (pulse_out[2]) hi++;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL cfg_change t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (hi != 8) begin
      miscompares++;
      $display("FAIL cfg_change_len active=%0d required 8", hi);
    end
  endtask

  task automatic test_simultaneous();
    int dn_at [NCH];
    for (int i = 0; i < NCH; i++) begin
      set_cfg(i, i + 1, 0, 1, 0, 1'b0);
      dn_at[i] = -1;
    end
    trig = 4'b1111;
    for (int t = 1; t <= 8; t++) begin
      tick();
      trig = '0;
      for (int i = 0; i < NCH; i++) if (done[i]) dn_at[i] = t;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL simultaneous t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    for (int i = 0; i < NCH; i++) begin
      vectors++;
      if (dn_at[i] != i + 2) begin
        miscompares++;
        $display("FAIL simultaneous_done ch=%0d at=%0d required %0d", i, dn_at[i], i + 2);
      end
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    set_cfg(3, 2, 0, 5, 2, 1'b1);
    trig = 4'b1000;
    for (int t = 1; t <= 14; t++) begin
      tick();
      trig = '0; abort = 1'b0;
      if (t == 4) begin abort = 1'b1; trig = 4'b1000; end
      if (done[3]) dn++;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL abort t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
      if (t == 5) begin
        vectors++;
        if (busy[3] !== 1'b0 || pulse_out[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL abort_gap busy=%b pulse=%b required 0/1", busy[3], pulse_out[3]);
        end
      end
    end
    vectors++;
    if (dn != 0) begin
      miscompares++;
      $display("FAIL abort_done strobes=%0d required 0", dn);
    end
    cfg_pol[3] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    set_cfg(0, 5, 0, 1, 0, 1'b0);
    trig = 4'b0001;
    for (int t = 1; t <= 10; t++) begin
      tick();
      trig = '0; rst = 1'b0;
      if (t == 2) begin rst = 1'b1; trig = 4'b0001; end
      if (done[0]) dn++;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL reset_mid t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (dn != 0) begin
      miscompares++;
      $display("FAIL reset_mid_done strobes=%0d required 0", dn);
    end
  endtask

  task automatic test_zero();
    logic [6:1] seen;
    set_cfg(2, 0, 0, 0, 1, 1'b0);
    trig = 4'b0100;
    for (int t = 1; t <= 6; t++) begin
      tick();
      trig = '0;
      seen[t] = pulse_out[2];
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL zero t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (seen !== 6'b000101) begin
      miscompares++;
      $display("FAIL zero_shape got=%b required 000101", seen);
    end
  endtask

  task automatic test_back_to_back();
    int dn = 0;
    set_cfg(1, 2, 1, 1, 0, 1'b0);
    trig = 4'b0010;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done[1]) dn++;
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL back_to_back t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    trig = '0;
    repeat (5) tick();
    vectors++;
    if (dn != 5) begin
      miscompares++;
      $display("FAIL back_to_back_count done=%0d required 5", dn);
    end
  endtask

  task automatic test_max();
    int hi = 0, first = -1;
    set_cfg(0, 255, 255, 1, 0, 1'b0);
    trig = 4'b0001;
    for (int t = 1; t <= 515; t++) begin
      tick();
      trig = '0;
      if (pulse_out[0]) begin hi++; if (first < 0) first = t; end
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL max t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    vectors++;
    if (hi != 255 || first != 256) begin
      miscompares++;
      $display("FAIL max_shape active=%0d first=%0d required 255/256", hi, first);
    end
  endtask

  task automatic test_random();
    for (int t = 1; t <= 2000; t++) begin
      for (int i = 0; i < NCH; i++) begin
        cfg_len[i*LW +: LW] = LW'($urandom_range(0, 5));
        cfg_dly[i*LW +: LW] = LW'($urandom_range(0, 4));
        cfg_gap[i*LW +: LW] = LW'($urandom_range(0, 4));
        cfg_rep[i*RW +: RW] = RW'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) cfg_pol[i] = ~cfg_pol[i];
        trig[i] = ($urandom_range(0, 3) == 0);
      end
      abort = ($urandom_range(0, 99) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      tick();
      vectors++;
      if (pulse_out !== exp_pulse() || busy !== exp_busy() || done !== exp_done()) begin
        miscompares++;
        $display("FAIL random t=%0d pulse=%b exp=%b busy=%b exp=%b done=%b exp=%b",
                 t, pulse_out, exp_pulse(), busy, exp_busy(), done, exp_done());
      end
    end
    trig = '0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; trig = '0;
    cfg_len = '0; cfg_dly = '0; cfg_gap = '0; cfg_rep = '0; cfg_pol = '0;
    test_reset();
    test_single();
    test_repeat();
    test_cfg_change();
    test_simultaneous();
    test_abort();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    test_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
